// File: rtl/move_gen_master.sv
// Avalon-MM master that loads a board into a move-generator slave, starts it, polls for
// completion and streams the resulting move words to a ready/valid consumer.
module move_gen_master #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned BOARD_WORDS = 8,
  parameter int unsigned BOARD_BASE  = 2,
  parameter int unsigned CTRL_ADDR   = 0,
  parameter int unsigned COUNT_ADDR  = 1,
  parameter int unsigned MOVE_BASE   = 16,
  parameter int unsigned MAX_MOVES   = 256,
  parameter int unsigned POLL_LIMIT  = 4096
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [DATA_WIDTH*BOARD_WORDS-1:0] board_in,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [8:0]                        move_count,
  output logic [DATA_WIDTH-1:0]             move_data,
  output logic                              move_valid,
  input  logic                              move_ready,
  output logic [ADDR_WIDTH-1:0]             master_address,
  output logic                              master_read,
  output logic                              master_write,
  output logic [DATA_WIDTH-1:0]             master_writedata,
  output logic [DATA_WIDTH/8-1:0]           master_byteenable,
  input  logic [DATA_WIDTH-1:0]             master_readdata,
  input  logic                              master_waitrequest
);

  localparam int unsigned BOARD_W = DATA_WIDTH * BOARD_WORDS;
  localparam int unsigned BIDX_W  = (BOARD_WORDS > 1) ? $clog2(BOARD_WORDS) : 1;
  localparam int unsigned POLL_W  = $clog2(POLL_LIMIT + 1);
  localparam int unsigned CNT_W   = 9;

  typedef enum logic [2:0] {
    IDLE, WR_BOARD, WR_GO, POLL, RD_COUNT, RD_MOVE, OUT_MOVE, FINISH
  } state_e;

  state_e                  state_q, state_d;
  logic [BOARD_W-1:0]      board_q, board_d;
  logic [BIDX_W-1:0]       bidx_q, bidx_d;
  logic [POLL_W-1:0]       poll_q, poll_d;
  logic [CNT_W-1:0]        midx_q, midx_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0]   mdata_q, mdata_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic                    xfer_c;
  logic [BIDX_W-1:0]       bidx_nxt_c;
  logic [CNT_W-1:0]        midx_nxt_c;
  logic [CNT_W-1:0]        count_clamp_c;

  assign xfer_c        = (rd_q | wr_q) & ~master_waitrequest;
  assign bidx_nxt_c    = bidx_q + BIDX_W'(1);
  assign midx_nxt_c    = midx_q + CNT_W'(1);
  assign count_clamp_c = (master_readdata > DATA_WIDTH'(MAX_MOVES)) ? CNT_W'(MAX_MOVES)
                                                                    : CNT_W'(master_readdata);

  // Strobes are registered, so a completing access can be followed by the next one
  // in the very next cycle with its new address/data already set up.
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    bidx_d  = bidx_q;
    poll_d  = poll_q;
    midx_d  = midx_q;
    count_d = count_q;
    mdata_d = mdata_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    error_d = error_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          board_d = board_in;
          error_d = 1'b0;
          count_d = '0;
          bidx_d  = '0;
          addr_d  = ADDR_WIDTH'(BOARD_BASE);
          wdata_d = board_in[DATA_WIDTH-1:0];
          wr_d    = 1'b1;
          state_d = WR_BOARD;
        end
      end
      WR_BOARD: begin
        if (xfer_c) begin
          if (bidx_q == BIDX_W'(BOARD_WORDS - 1)) begin
            addr_d  = ADDR_WIDTH'(CTRL_ADDR);
            wdata_d = DATA_WIDTH'(1);
            state_d = WR_GO;
          end else begin
            bidx_d  = bidx_nxt_c;
            addr_d  = ADDR_WIDTH'(BOARD_BASE) + ADDR_WIDTH'(bidx_nxt_c);
            wdata_d = board_q[int'(bidx_nxt_c)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      WR_GO: begin
        if (xfer_c) begin
          wr_d    = 1'b0;
          rd_d    = 1'b1;
          addr_d  = ADDR_WIDTH'(CTRL_ADDR);
          poll_d  = '0;
          state_d = POLL;
        end
      end
      POLL: begin
        if (xfer_c) begin
          if (master_readdata[1]) begin
            addr_d  = ADDR_WIDTH'(COUNT_ADDR);
            state_d = RD_COUNT;
          end else if (poll_q == POLL_W'(POLL_LIMIT - 1)) begin
            rd_d    = 1'b0;
            error_d = 1'b1;
            count_d = '0;
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            poll_d = poll_q + POLL_W'(1);
          end
        end
      end
      RD_COUNT: begin
        if (xfer_c) begin
          count_d = count_clamp_c;
          if (count_clamp_c == '0) begin
            rd_d    = 1'b0;
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            midx_d  = '0;
            addr_d  = ADDR_WIDTH'(MOVE_BASE);
            state_d = RD_MOVE;
          end
        end
      end
      RD_MOVE: begin
        if (xfer_c) begin
          rd_d    = 1'b0;
          mdata_d = master_readdata;
          valid_d = 1'b1;
          state_d = OUT_MOVE;
        end
      end
      OUT_MOVE: begin
        if (move_ready) begin
          valid_d = 1'b0;
          midx_d  = midx_nxt_c;
          if (midx_nxt_c == count_q) begin
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            rd_d    = 1'b1;
            addr_d  = ADDR_WIDTH'(MOVE_BASE) + ADDR_WIDTH'(midx_nxt_c);
            state_d = RD_MOVE;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      board_q <= '0;
      bidx_q  <= '0;
      poll_q  <= '0;
      midx_q  <= '0;
      count_q <= '0;
      mdata_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      bidx_q  <= bidx_d;
      poll_q  <= poll_d;
      midx_q  <= midx_d;
      count_q <= count_d;
      mdata_q <= mdata_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
  assign move_count        = count_q;
  assign move_data         = mdata_q;
  assign move_valid        = valid_q;
  assign master_address    = addr_q;
  assign master_read       = rd_q;
  assign master_write      = wr_q;
  assign master_writedata  = wdata_q;
  assign master_byteenable = '1;

endmodule
